fpu_wb_initiator: RTL and testbench



---
 rtl/fpu_wb_pkg.sv | 42 ++++
 rtl/fpu_wb_initiator_if.sv | 29 ++
 rtl/fpu_wb_xfer.sv | 72 +++++++
 rtl/fpu_wb_initiator.sv | 198 +++++++++++++++++++
 tb/tb_fpu_wb_initiator.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_wb_pkg
// Brief   : Register map, state encoding and helpers for the FPU WB initiator.
// Rev     : 1.0  initial release
// ============================================================================
package fpu_wb_pkg;

  localparam int FLAGS_W = 5;
  localparam int OP_W    = 12;
  localparam int RM_W    = 3;

  localparam logic [31:0] OFF_A   = 32'h0000_0000;
  localparam logic [31:0] OFF_B   = 32'h0000_0004;
  localparam logic [31:0] OFF_C   = 32'h0000_0008;
  localparam logic [31:0] OFF_RM  = 32'h0000_000C;
  localparam logic [31:0] OFF_RES = 32'h0000_0010;
  localparam logic [31:0] OFF_FLG = 32'h0000_0014;
  localparam logic [31:0] OFF_ST  = 32'h0000_0018;
  localparam logic [31:0] OFF_OP  = 32'h0000_001C;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WR_A   = 4'd1,
    ST_WR_B   = 4'd2,
    ST_WR_C   = 4'd3,
    ST_WR_RM  = 4'd4,
    ST_WR_OP  = 4'd5,
    ST_POLL   = 4'd6,
    ST_RD_RES = 4'd7,
    ST_RD_FLG = 4'd8,
    ST_WR_CLR = 4'd9,
    ST_RESP   = 4'd10
  } fpu_wb_state_e;

  // Operation register image: bit OP_W is the slave's valid_in strobe.
  function automatic logic [31:0] op_word(input logic valid, input logic [OP_W-1:0] op);
    return {{(32-OP_W-1){1'b0}}, valid, op};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_wb_initiator_if.sv
`default_nettype none
// ============================================================================
// Module  : fpu_wb_initiator_if
// Brief   : Wishbone classic bus between the FPU initiator and its slave.
// Rev     : 1.0  initial release
// ============================================================================
interface fpu_wb_initiator_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/fpu_wb_xfer.sv
`default_nettype none
// ============================================================================
// Module  : fpu_wb_xfer
// Brief   : Single Wishbone classic read/write with a start/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
module fpu_wb_xfer (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_we,
  input  logic [31:0]        i_adr,
  input  logic [31:0]        i_wdata,
  output logic               o_done,
  output logic [31:0]        o_rdata,
  fpu_wb_initiator_if.master wb
);

  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_done;
  logic [31:0] r_rdata;

  // Bus is released on the ack edge, so done arrives during the idle cycle
  // and a launch on done yields exactly one idle cycle between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= 32'h0;
      r_dat   <= 32'h0;
      r_done  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_done <= 1'b0;
      if (r_cyc) begin
        if (wb.wbm_ack_i) begin
          r_cyc  <= 1'b0;
          r_we   <= 1'b0;
          r_sel  <= 4'h0;
          r_adr  <= 32'h0;
          r_dat  <= 32'h0;
          r_done <= 1'b1;
          if (!r_we) begin
            r_rdata <= wb.wbm_dat_i;
          end
        end
      end else if (i_start) begin
        r_cyc <= 1'b1;
        r_we  <= i_we;
        r_sel <= 4'hF;
        r_adr <= i_adr;
        r_dat <= i_we ? i_wdata : 32'h0;
      end
    end
  end

  assign wb.wbm_cyc_o = r_cyc;
  assign wb.wbm_stb_o = r_cyc;
  assign wb.wbm_we_o  = r_we;
  assign wb.wbm_sel_o = r_sel;
  assign wb.wbm_adr_o = r_adr;
  assign wb.wbm_dat_o = r_dat;
  assign o_done       = r_done;
  assign o_rdata      = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fpu_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module  : fpu_wb_initiator
// Brief   : Sequences one FPU command over Wishbone: write, poll, read back.
// Rev     : 1.0  initial release
// ============================================================================
module fpu_wb_initiator
  import fpu_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          POLL_LIMIT = 1024,
  parameter int          POLL_W     = 11
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [31:0]        cmd_a_i,
  input  logic [31:0]        cmd_b_i,
  input  logic [31:0]        cmd_c_i,
  input  logic [RM_W-1:0]    cmd_rm_i,
  input  logic [OP_W-1:0]    cmd_op_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_result_o,
  output logic [FLAGS_W-1:0] rsp_flags_o,
  output logic               rsp_timeout_o,
  fpu_wb_initiator_if.master wbm
);

  localparam logic [POLL_W-1:0] c_poll_last = POLL_W'(POLL_LIMIT - 1);

  fpu_wb_state_e        r_state;
  fpu_wb_state_e        w_tgt;
  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic                 r_timeout;
  logic [31:0]          r_b;
  logic [31:0]          r_c;
  logic [RM_W-1:0]      r_rm;
  logic [OP_W-1:0]      r_op;
  logic [31:0]          r_result;
  logic [FLAGS_W-1:0]   r_flags;
  logic [POLL_W-1:0]    r_poll;

  logic                 w_start;
  logic                 w_we;
  logic [31:0]          w_off;
  logic [31:0]          w_adr;
  logic [31:0]          w_wdata;
  logic                 w_done;
  logic [31:0]          w_rdata;

  // Launch decode: the next bus state and whether its transfer starts now.
  always_comb begin
    w_start = 1'b0;
    w_tgt   = r_state;
    case (r_state)
      ST_IDLE:   begin w_start = cmd_valid_i; w_tgt = ST_WR_A;   end
      ST_WR_A:   begin w_start = w_done;      w_tgt = ST_WR_B;   end
      ST_WR_B:   begin w_start = w_done;      w_tgt = ST_WR_C;   end
      ST_WR_C:   begin w_start = w_done;      w_tgt = ST_WR_RM;  end
      ST_WR_RM:  begin w_start = w_done;      w_tgt = ST_WR_OP;  end
      ST_WR_OP:  begin w_start = w_done;      w_tgt = ST_POLL;   end
      ST_POLL: begin
        w_start = w_done;
        if (w_rdata[0]) begin
          w_tgt = ST_RD_RES;
        end else if (r_poll == c_poll_last) begin
          w_tgt = ST_WR_CLR;
        end else begin
          w_tgt = ST_POLL;
        end
      end
      ST_RD_RES: begin w_start = w_done;      w_tgt = ST_RD_FLG; end
      ST_RD_FLG: begin w_start = w_done;      w_tgt = ST_WR_CLR; end
      default:   ;
    endcase
  end

  // Transfer descriptor for the state being entered. WR_A only follows
  // IDLE, so its data comes straight from the command port.
  always_comb begin
    w_we    = 1'b1;
    w_off   = OFF_A;
    w_wdata = 32'h0;
    case (w_tgt)
      ST_WR_A:   begin w_off = OFF_A;   w_wdata = cmd_a_i;                          end
      ST_WR_B:   begin w_off = OFF_B;   w_wdata = r_b;                              end
      ST_WR_C:   begin w_off = OFF_C;   w_wdata = r_c;                              end
      ST_WR_RM:  begin w_off = OFF_RM;  w_wdata = {{(32-RM_W){1'b0}}, r_rm};        end
      ST_WR_OP:  begin w_off = OFF_OP;  w_wdata = op_word(1'b1, r_op);              end
      ST_POLL:   begin w_off = OFF_ST;  w_we    = 1'b0;                             end
      ST_RD_RES: begin w_off = OFF_RES; w_we    = 1'b0;                             end
      ST_RD_FLG: begin w_off = OFF_FLG; w_we    = 1'b0;                             end
      ST_WR_CLR: begin w_off = OFF_OP;  w_wdata = op_word(1'b0, r_op);              end
      default:   ;
    endcase
  end

  assign w_adr = BASE_ADDR + w_off;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_b         <= 32'h0;
      r_c         <= 32'h0;
      r_rm        <= '0;
      r_op        <= '0;
      r_result    <= 32'h0;
      r_flags     <= '0;
      r_poll      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_b         <= cmd_b_i;
            r_c         <= cmd_c_i;
            r_rm        <= cmd_rm_i;
            r_op        <= cmd_op_i;
            r_cmd_ready <= 1'b0;
            r_timeout   <= 1'b0;
            r_result    <= 32'h0;
            r_flags     <= '0;
            r_poll      <= '0;
            r_state     <= w_tgt;
          end
        end
        ST_POLL: begin
          if (w_done) begin
            if (!w_rdata[0]) begin
              r_poll <= r_poll + POLL_W'(1);
              if (r_poll == c_poll_last) begin
                r_timeout <= 1'b1;
                r_result  <= 32'h0;
                r_flags   <= '0;
              end
            end
            r_state <= w_tgt;
          end
        end
        ST_RD_RES: begin
          if (w_done) begin
            r_result <= w_rdata;
            r_state  <= w_tgt;
          end
        end
        ST_RD_FLG: begin
          if (w_done) begin
            r_flags <= w_rdata[FLAGS_W-1:0];
            r_state <= w_tgt;
          end
        end
        ST_WR_CLR: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          if (w_done) begin
            r_state <= w_tgt;
          end
        end
      endcase
    end
  end

  fpu_wb_xfer u_xfer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_start (w_start),
    .i_we    (w_we),
    .i_adr   (w_adr),
    .i_wdata (w_wdata),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .wb      (wbm)
  );

  assign cmd_ready_o   = r_cmd_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_result_o  = r_result;
  assign rsp_flags_o   = r_flags;
  assign rsp_timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_wb_initiator
// Brief   : Directed self-checking bench with a wait-state FPU slave model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpu_wb_initiator;
  import fpu_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = 32'h0, cmd_b = 32'h0, cmd_c = 32'h0;
  logic [2:0]  cmd_rm = 3'h0;
  logic [11:0] cmd_op = 12'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_wb_initiator_if bus ();

  fpu_wb_initiator #(.BASE_ADDR(BASE), .POLL_LIMIT(4), .POLL_W(3)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .cmd_c_i       (cmd_c),
    .cmd_rm_i      (cmd_rm),
    .cmd_op_i      (cmd_op),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_flags_o   (rsp_flags),
    .rsp_timeout_o (rsp_timeout),
    .wbm           (bus)
  );

  // FPU slave model: random wait states, status goes done after done_after polls.
  int          ws_max = 0;
  int          done_after = 3;
  logic [31:0] s_result = 32'h0;
  logic [4:0]  s_flags = 5'h0;
  int          s_wait = 0, s_tgt = 0, s_polls = 0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= 32'h0;
      s_wait        <= 0;
      s_polls       <= 0;
    end else begin
      bus.wbm_ack_i <= 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
        if (s_wait >= s_tgt) begin
          bus.wbm_ack_i <= 1'b1;
          s_wait        <= 0;
          s_tgt         <= int'($urandom_range(32'(ws_max), 0));
          log_adr.push_back(bus.wbm_adr_o);
          log_we.push_back(bus.wbm_we_o);
          log_dat.push_back(bus.wbm_dat_o);
          if (!bus.wbm_we_o) begin
            case (bus.wbm_adr_o - BASE)
              OFF_RES: bus.wbm_dat_i <= s_result;
              OFF_FLG: bus.wbm_dat_i <= {27'h0, s_flags};
              OFF_ST: begin
                bus.wbm_dat_i <= (s_polls >= done_after) ? 32'h1 : 32'h0;
                s_polls       <= s_polls + 1;
              end
              default: bus.wbm_dat_i <= 32'h0;
            endcase
          end else if (bus.wbm_adr_o == BASE + OFF_OP && bus.wbm_dat_o[12]) begin
            s_polls <= 0;
          end
        end else begin
          s_wait <= s_wait + 1;
        end
      end
    end
  end

  // Bus monitor: idle gap before each cycle, stability while strobed, sel rule.
  int          idle_run = 0, stab_err = 0, sel_err = 0;
  int          gap_q[$];
  logic        m_prev = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = 32'h0, m_dat = 32'h0;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o) begin
      if (!m_prev) begin
        m_adr <= bus.wbm_adr_o;
        m_we  <= bus.wbm_we_o;
        m_dat <= bus.wbm_dat_o;
        gap_q.push_back(idle_run);
        idle_run <= 0;
      end else if (bus.wbm_adr_o !== m_adr || bus.wbm_we_o !== m_we || bus.wbm_dat_o !== m_dat) begin
        stab_err <= stab_err + 1;
      end
      if (bus.wbm_sel_o !== 4'hF || bus.wbm_stb_o !== 1'b1) sel_err <= sel_err + 1;
    end else begin
      idle_run <= idle_run + 1;
      if (bus.wbm_sel_o !== 4'h0 || bus.wbm_stb_o !== 1'b0) sel_err <= sel_err + 1;
    end
    m_prev <= bus.wbm_cyc_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, b, c, input logic [2:0] rm, input logic [11:0] op);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_rm = rm; cmd_op = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 32'(cmd_ready), 32'h0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_arrives", 32'(rsp_valid), 32'h1);
  endtask

  // Holds rsp_ready low for `hold` cycles, then consumes the response.
  task automatic consume(input int hold, input logic [31:0] e_res, input logic [4:0] e_flg,
                         input logic e_to);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_result", rsp_result, e_res);
      @(negedge clk);
    end
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_flags", 32'(rsp_flags), 32'(e_flg));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'h0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'h1);
  endtask

  task automatic check_log(input int l0, input int g0, input logic [31:0] a, b, c,
                           input logic [2:0] rm, input logic [11:0] op, input int npoll,
                           input logic tmo);
    logic [31:0] e_adr[$];
    logic [31:0] e_dat[$];
    logic        e_we[$];
    e_adr.push_back(BASE + 32'h00); e_we.push_back(1'b1); e_dat.push_back(a);
    e_adr.push_back(BASE + 32'h04); e_we.push_back(1'b1); e_dat.push_back(b);
    e_adr.push_back(BASE + 32'h08); e_we.push_back(1'b1); e_dat.push_back(c);
    e_adr.push_back(BASE + 32'h0C); e_we.push_back(1'b1); e_dat.push_back({29'h0, rm});
    e_adr.push_back(BASE + 32'h1C); e_we.push_back(1'b1); e_dat.push_back({19'h0, 1'b1, op});
    for (int i = 0; i < npoll; i++) begin
      e_adr.push_back(BASE + 32'h18); e_we.push_back(1'b0); e_dat.push_back(32'h0);
    end
    if (!tmo) begin
      e_adr.push_back(BASE + 32'h10); e_we.push_back(1'b0); e_dat.push_back(32'h0);
      e_adr.push_back(BASE + 32'h14); e_we.push_back(1'b0); e_dat.push_back(32'h0);
    end
    e_adr.push_back(BASE + 32'h1C); e_we.push_back(1'b1); e_dat.push_back({19'h0, 1'b0, op});
    chk("bus_txn_count", 32'(log_adr.size() - l0), 32'(e_adr.size()));
    for (int i = 0; i < e_adr.size(); i++) begin
      if (l0 + i < log_adr.size()) begin
        chk($sformatf("txn%0d_adr", i), log_adr[l0+i], e_adr[i]);
        chk($sformatf("txn%0d_we", i), 32'(log_we[l0+i]), 32'(e_we[i]));
        if (e_we[i]) chk($sformatf("txn%0d_dat", i), log_dat[l0+i], e_dat[i]);
      end
    end
    for (int i = 1; i < e_adr.size(); i++) begin
      if (g0 + i < gap_q.size()) chk($sformatf("gap_before_txn%0d", i), 32'(gap_q[g0+i]), 32'h1);
    end
    chk("bus_stable", 32'(stab_err), 32'h0);
    chk("sel_rule", 32'(sel_err), 32'h0);
  endtask

  initial begin
    int l0, g0, n;
    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'h0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_result", rsp_result, 32'h0);

    // Basic add, zero wait states
    s_result = 32'h4040_0000; s_flags = 5'h00; done_after = 3; ws_max = 0;
    l0 = log_adr.size(); g0 = gap_q.size();
    issue(32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 3'd0, 12'h001);
    wait_rsp();
    check_log(l0, g0, 32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 3'd0, 12'h001, 4, 1'b0);
    consume(0, 32'h4040_0000, 5'h00, 1'b0);

    // Same command with 0-5 random wait states
    ws_max = 5;
    l0 = log_adr.size(); g0 = gap_q.size();
    issue(32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 3'd0, 12'h001);
    wait_rsp();
    check_log(l0, g0, 32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 3'd0, 12'h001, 4, 1'b0);
    consume(0, 32'h4040_0000, 5'h00, 1'b0);

    // Poll timeout: status never done, limit is 4 reads
    ws_max = 2; done_after = 1000; s_result = 32'hDEAD_BEEF; s_flags = 5'h1F;
    l0 = log_adr.size(); g0 = gap_q.size();
    issue(32'hAAAA_0001, 32'h5555_0002, 32'h0F0F_0003, 3'd5, 12'h800);
    wait_rsp();
    check_log(l0, g0, 32'hAAAA_0001, 32'hAAAA_0001 ^ 32'hFFFF_0003, 32'h0F0F_0003, 3'd5, 12'h800, 4, 1'b1);
    consume(0, 32'h0, 5'h00, 1'b1);

    // Response backpressure with non-zero flags
    ws_max = 1; done_after = 1; s_result = 32'hCAFE_F00D; s_flags = 5'h15;
    l0 = log_adr.size(); g0 = gap_q.size();
    issue(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 3'd3, 12'h040);
    wait_rsp();
    check_log(l0, g0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 3'd3, 12'h040, 2, 1'b0);
    consume(10, 32'hCAFE_F00D, 5'h15, 1'b0);

    // Reset while a status read is strobed
    ws_max = 3; done_after = 1000;
    issue(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'd1, 12'h002);
    n = 0;
    while (!(bus.wbm_stb_o === 1'b1 && bus.wbm_adr_o === BASE + 32'h18) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("poll_stb_seen", 32'(bus.wbm_adr_o), BASE + 32'h18);
    rst = 1'b1;
    #1;
    chk("midrst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("midrst_stb", 32'(bus.wbm_stb_o), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);

    s_result = 32'h4040_0000; s_flags = 5'h02; done_after = 3;
    l0 = log_adr.size(); g0 = gap_q.size();
    issue(32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd2, 12'h001);
    wait_rsp();
    check_log(l0, g0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd2, 12'h001, 4, 1'b0);
    consume(0, 32'h4040_0000, 5'h02, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
